// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub
// Brief    : Bit-serial add/subtract, one full-adder cell, LSB first,
//            valid/ready on both the operand and the result side.
// Revision : 1.0  initial release
// ============================================================================
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_PRE_MSB = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cmsb;
  logic [CW-1:0]    r_count;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic             w_sum;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_result_next;

  // The single full-adder cell.
  assign w_sum         = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_carry_next  = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) |
                         (r_op_b[0] & r_carry);
  assign w_result_next = {w_sum, r_result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (r_count == C_LAST) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_cmsb     <= 1'b0;
      r_count    <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry.
            r_op_a   <= a;
            r_op_b   <= b ^ {WIDTH{sub}};
            r_carry  <= sub;
            r_count  <= '0;
            r_result <= '0;
          end
        end
        RUN: begin
          r_op_a   <= {1'b0, r_op_a[WIDTH-1:1]};
          r_op_b   <= {1'b0, r_op_b[WIDTH-1:1]};
          r_carry  <= w_carry_next;
          r_result <= w_result_next;
          r_count  <= r_count + 1'b1;
          if (r_count == C_PRE_MSB) begin
            r_cmsb <= w_carry_next;
          end
          if (r_count == C_LAST) begin
            r_cout     <= w_carry_next;
            r_overflow <= r_cmsb ^ w_carry_next;
            r_zero     <= (w_result_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub
// Brief    : Directed and random self-checking bench for serial_add_sub.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  int errors = 0;
  int checks = 0;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits in IDLE, presents operands for one accept edge.
  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic si);
    int n = 0;
    while (!in_ready && n < 4 * WIDTH) begin
      tick();
      n++;
    end
    check("issue_ready", 32'(in_ready), 32'd1);
    a = ai;
    b = bi;
    sub = si;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", 32'(in_ready), 32'd0);
  endtask

  // Counts edges after the accept edge until out_valid; checks latency and values.
  task automatic expect_result(input string tag, input logic [WIDTH-1:0] er,
                               input logic ec, input logic eo, input logic ez);
    int lat = 0;
    while (!out_valid && lat < 4 * WIDTH) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic stall(input int cycles);
    logic [WIDTH-1:0] held;
    held = result;
    out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_result", 32'(result), 32'(held));
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_valid", 32'(out_valid), 32'd0);
    check("consume_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic si, input logic [WIDTH-1:0] er, input logic ec,
                       input logic eo, input logic ez);
    issue(ai, bi, si);
    expect_result(tag, er, ec, eo, ez);
    consume();
  endtask

  initial begin
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] ra, rb, rr;
    logic             rs, ro;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, cout, overflow, zero}, 32'd0);

    do_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure with a pending request held on the input side.
    issue(8'h22, 8'h11, 1'b0);
    expect_result("bp_first", 8'h33, 1'b0, 1'b0, 1'b0);
    a = 8'h01;
    b = 8'h02;
    sub = 1'b0;
    in_valid = 1'b1;
    stall(5);
    check("bp_cout_held", 32'(cout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    expect_result("bp_second", 8'h03, 1'b0, 1'b0, 1'b0);
    consume();

    // Reset sampled on the third RUN edge.
    issue(8'hC3, 8'h5A, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, cout, overflow, zero}, 32'd0);
    do_op("post_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Random sweep against a wide reference with sign-based overflow.
    for (int n = 0; n < 200; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        ext = {1'b0, ra} + {1'b0, ~rb} + (WIDTH + 1)'(1);
        rr = ext[WIDTH-1:0];
        ro = (ra[WIDTH-1] != rb[WIDTH-1]) && (rr[WIDTH-1] != ra[WIDTH-1]);
      end else begin
        ext = {1'b0, ra} + {1'b0, rb};
        rr = ext[WIDTH-1:0];
        ro = (ra[WIDTH-1] == rb[WIDTH-1]) && (rr[WIDTH-1] != ra[WIDTH-1]);
      end
      issue(ra, rb, rs);
      expect_result("rand", rr, ext[WIDTH], ro, (rr == '0));
      stall($urandom_range(0, 3));
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial add/subtract unit built around a single full-adder cell and a carry flip-flop. Processes one operand bit per clock, LSB first.
- Used for area-constrained arithmetic in the in-order system, e.g. address or loop-count updates where a WIDTH-bit ripple adder is not justified.
- Accepts operands with a valid/ready handshake and returns a registered result with flags through a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 computes a+b; 1 computes a-b.
- out_valid  output  1  result and flags are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB; for subtraction, 1 means no borrow.
- overflow  output  1  signed overflow, equal to (carry into MSB) XOR (carry out of MSB).
- zero  output  1  result equals 0.

Behaviour:
- Reset (synchronous, wins over everything): state goes to IDLE. result, cout, overflow, zero, out_valid, carry flip-flop and bit counter are all cleared to 0. in_ready is 1 in the cycle after reset deasserts.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1 and out_valid=0. On an edge with in_valid=1, the unit latches:
  - opA = a
  - opB = b XOR {WIDTH{sub}}
  - carry = sub
  - count = 0
  - the result shift register is cleared
  - next state is RUN.
  With in_valid=0 the unit stays in IDLE.
- RUN: in_ready=0 and out_valid=0. On each edge:
  - s = opA[0] ^ opB[0] ^ carry; carry <= majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1.
  - s shifts into the result MSB while the result shifts right.
  - count increments.
  - On the edge that processes bit WIDTH-2, the carry it produces (the carry into the MSB) is saved to cmsb.
  - On the edge that processes bit WIDTH-1:
    - cout <= carry-out of that bit.
    - overflow <= cmsb XOR that carry-out.
    - zero <= (final result == 0).
    - next state is DONE.
  - in_valid is ignored throughout RUN.
- Latency: the operand accept edge is E0. Bits are processed on edges E1..EWIDTH. out_valid is first high after edge EWIDTH, i.e. WIDTH edges after acceptance.
- DONE: out_valid=1 and in_ready=0. result, cout, overflow and zero stay stable until the handshake completes. On an edge with out_ready=1 the state goes to IDLE and out_valid drops. Output values then hold until the next accept clears the result register.
- No overlap: a new operand set cannot be accepted in the same cycle that a result is consumed. Minimum issue interval is WIDTH+2 cycles.
- Reset mid-RUN or mid-DONE aborts the operation. No partial result is ever presented with out_valid=1.
- in_valid held high continuously causes back-to-back operations, each accepted in its IDLE cycle.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, sub=0 -> result=0x7F, cout=0, overflow=0, zero=0. out_valid rises exactly 8 edges after the accept edge.
- a=0x7F, b=0x01, add -> result=0x80, cout=0, overflow=1. Then a=0xFF, b=0x01, add -> result=0x00, cout=1, overflow=0, zero=1.
- a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands. Required: result and flags stay constant, in_ready=0 throughout, and no new accept occurs. After out_ready=1, IDLE follows and the pending operands are accepted on the next edge.
- Assert reset on the 3rd RUN edge -> the next cycle has in_ready=1, out_valid=0, result=0, cout=0, overflow=0, zero=0. A subsequent 0x01+0x01 gives 0x02.
- Random sweep, 200 operations with random a, b, sub and random out_ready stalls. Every result, cout and overflow matches a reference (a ± b) computed to WIDTH+1 bits, and every latency equals WIDTH.
